// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous data memory.
// Serialises M0/M1 accesses, flags out-of-range addresses, and sequences the final memory dump.
module data_mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int MEMORY_DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     prio_fixed,

    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_ack,
    output logic                     m0_err,
    output logic [DATA_WIDTH-1:0]    m0_rdata,

    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    output logic                     m1_ack,
    output logic                     m1_err,
    output logic [DATA_WIDTH-1:0]    m1_rdata,

    input  logic                     dump_req,
    output logic                     dump_busy,

    output logic                     mem_read_En,
    output logic                     mem_write_En,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out,
    output logic                     mem_process_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DUMP} state_e;

    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LIMIT = ADDRESS_WIDTH'(MEMORY_DEPTH);

    state_e                   state_q, state_d;
    logic                     owner_q, owner_d;      // 0 = M0, 1 = M1
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     last_m1_q, last_m1_d;  // port granted most recently
    logic                     dump_pend_q, dump_pend_d;

    logic win_m1;
    logic out_of_range;
    logic ack;
    logic err;
    logic [DATA_WIDTH-1:0] rdata;

    assign out_of_range = (addr_q >= DEPTH_LIMIT);

    // On contention the round-robin winner is the port that was not granted last.
    always_comb begin
        if (m0_req && m1_req) begin
            win_m1 = prio_fixed ? 1'b0 : ~last_m1_q;
        end else begin
            win_m1 = m1_req;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_m1_q   <= 1'b1;
            dump_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_m1_q   <= last_m1_d;
            dump_pend_q <= dump_pend_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_m1_d = last_m1_q;
        // A request arriving during DUMP re-arms the pending flag rather than being lost.
        dump_pend_d = dump_req | (dump_pend_q & (state_q != DUMP));

        unique case (state_q)
            IDLE: begin
                if (dump_pend_q) begin
                    state_d = DUMP;
                end else if (m0_req || m1_req) begin
                    owner_d   = win_m1;
                    last_m1_d = win_m1;
                    we_d      = win_m1 ? m1_we    : m0_we;
                    addr_d    = win_m1 ? m1_addr  : m0_addr;
                    wdata_d   = win_m1 ? m1_wdata : m0_wdata;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = (!out_of_range && !we_q) ? RESP : IDLE;
            end
            RESP: state_d = IDLE;
            DUMP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack              = 1'b0;
        err              = 1'b0;
        rdata            = '0;
        mem_read_En      = 1'b0;
        mem_write_En     = 1'b0;
        mem_address      = '0;
        mem_data_in      = '0;
        mem_process_done = 1'b0;

        unique case (state_q)
            ISSUE: begin
                if (out_of_range) begin
                    ack = 1'b1;
                    err = 1'b1;
                end else if (we_q) begin
                    mem_write_En = 1'b1;
                    mem_address  = addr_q;
                    mem_data_in  = wdata_q;
                    ack          = 1'b1;
                end else begin
                    mem_read_En = 1'b1;
                    mem_address = addr_q;
                end
            end
            RESP: begin
                ack   = 1'b1;
                rdata = mem_data_out;
            end
            DUMP:    mem_process_done = 1'b1;
            default: ;
        endcase

        m0_ack   = ack & ~owner_q;
        m0_err   = err & ~owner_q;
        m0_rdata = owner_q ? '0 : rdata;
        m1_ack   = ack & owner_q;
        m1_err   = err & owner_q;
        m1_rdata = owner_q ? rdata : '0;
    end

    assign dump_busy = dump_pend_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a behavioural memory, a scoreboard of expected acks,
// a table of single-port transactions, and hand-written contention/dump/reset sequences.
module tb_data_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rstN;
    logic          prio_fixed;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          dump_req, dump_busy;
    logic          mem_read_En, mem_write_En, mem_process_done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEMORY_DEPTH(4096)) dut (
        .clk(clk), .rstN(rstN), .prio_fixed(prio_fixed),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dump_req(dump_req), .dump_busy(dump_busy),
        .mem_read_En(mem_read_En), .mem_write_En(mem_write_En),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_process_done(mem_process_done)
    );

    always #5 clk = ~clk;

    // Single-port memory with one-cycle synchronous read.
    logic [DW-1:0] tb_mem [4096];
    always @(posedge clk) begin
        if (mem_write_En) tb_mem[mem_address[11:0]] <= mem_data_in;
        if (mem_read_En)  mem_data_out <= tb_mem[mem_address[11:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    typedef struct {
        bit            port;
        bit            err;
        logic [DW-1:0] rdata;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    // Scoreboard: every ack pops the oldest expectation.
    always @(negedge clk) begin
        if (rstN && (mem_read_En || mem_write_En))
            check("strobe_excl", mem_read_En & mem_write_En, 0);
        if (rstN && (m0_ack || m1_ack)) begin
            check("ack_excl", m0_ack & m1_ack, 0);
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("ack_port", m1_ack, mon_e.port);
                if (m1_ack) begin
                    check("m1_err", m1_err, mon_e.err);
                    check("m1_rdata", m1_rdata, mon_e.rdata);
                    check("m0_quiet", {m0_err, m0_rdata}, 0);
                end else begin
                    check("m0_err", m0_err, mon_e.err);
                    check("m0_rdata", m0_rdata, mon_e.rdata);
                    check("m1_quiet", {m1_err, m1_rdata}, 0);
                end
            end
        end
    end

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_lat;
        bit            exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    task automatic drive_port(input bit port, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // Single transaction; starts one negedge later so the DUT is back in IDLE.
    task automatic do_txn(input vec_t v);
        int lat;
        bit got;
        bit strobe;
        @(negedge clk);
        sb.push_back('{port: v.port, err: v.exp_err, rdata: v.exp_rdata});
        drive_port(v.port, v.we, v.addr, v.wdata);
        lat = 0; got = 0; strobe = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_read_En || mem_write_En) strobe = 1;
            if (v.port ? m1_ack : m0_ack) got = 1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("txn_latency", lat, v.exp_lat);
        check("txn_strobe", strobe, !v.exp_err);
        if (!got) sb.delete();
    endtask

    // Both ports held; each drops its request after its wanted number of acks.
    task automatic run_both(input int want0, input int want1, input string tag);
        int c0 = 0;
        int c1 = 0;
        int cyc = 0;
        while ((c0 < want0 || c1 < want1) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m0_ack) c0++;
            if (m1_ack) c1++;
            if (c0 >= want0) m0_req = 1'b0;
            if (c1 >= want1) m1_req = 1'b0;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check({tag, "_m0_acks"}, c0, want0);
        check({tag, "_m1_acks"}, c1, want1);
        if (c0 < want0 || c1 < want1) sb.delete();
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 1, 30'd5,          32'hDEADBEEF, 1, 0, 32'h0};
        vecs[1]  = '{0, 0, 30'd5,          32'h0,        2, 0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1, 30'd4095,       32'h12345678, 1, 0, 32'h0};
        vecs[3]  = '{1, 0, 30'd4095,       32'h0,        2, 0, 32'h12345678};
        vecs[4]  = '{1, 0, 30'd4096,       32'h0,        1, 1, 32'h0};
        vecs[5]  = '{0, 1, 30'd4096,       32'hFFFFFFFF, 1, 1, 32'h0};
        vecs[6]  = '{0, 0, 30'd4095,       32'h0,        2, 0, 32'h12345678};
        vecs[7]  = '{1, 1, 30'd7,          32'hA5A50F0F, 1, 0, 32'h0};
        vecs[8]  = '{0, 0, 30'd7,          32'h0,        2, 0, 32'hA5A50F0F};
        vecs[9]  = '{1, 1, 30'h3FFFFFFF,   32'h11111111, 1, 1, 32'h0};
        vecs[10] = '{1, 0, 30'd5,          32'h0,        2, 0, 32'hDEADBEEF};

        rstN = 1'b0; prio_fixed = 1'b0; dump_req = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;

        #12;
        check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        check("rst_mem", {mem_read_En, mem_write_En, mem_process_done, dump_busy}, 0);
        check("rst_mem_bus", {mem_address, mem_data_in}, 0);
        @(negedge clk);
        rstN = 1'b1;

        foreach (vecs[i]) do_txn(vecs[i]);

        // Round-robin: last grant was M1, so contention starts with M0.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{port: 0, err: 0, rdata: 32'hDEADBEEF});
            sb.push_back('{port: 1, err: 0, rdata: 32'hA5A50F0F});
        end
        drive_port(0, 0, 30'd5, '0);
        drive_port(1, 0, 30'd7, '0);
        run_both(2, 2, "rr");

        // Fixed priority: M1 waits while M0 keeps requesting.
        @(negedge clk);
        prio_fixed = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('{port: 0, err: 0, rdata: 32'h12345678});
        sb.push_back('{port: 1, err: 0, rdata: 32'hDEADBEEF});
        drive_port(0, 0, 30'd4095, '0);
        drive_port(1, 0, 30'd5, '0);
        run_both(3, 1, "fixed");
        prio_fixed = 1'b0;

        // Dump requested during a read's ISSUE; the read finishes first.
        @(negedge clk);
        sb.push_back('{port: 0, err: 0, rdata: 32'hDEADBEEF});
        drive_port(0, 0, 30'd5, '0);
        @(negedge clk);
        check("dump_issue_rd", mem_read_En, 1);
        m0_req = 1'b0;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check("dump_resp_ack", m0_ack, 1);
        check("dump_resp_busy", dump_busy, 1);
        check("dump_resp_done", mem_process_done, 0);
        @(negedge clk);
        check("dump_idle_done", mem_process_done, 0);
        check("dump_idle_busy", dump_busy, 1);
        @(negedge clk);
        check("dump_pulse", mem_process_done, 1);
        check("dump_pulse_busy", dump_busy, 1);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check("dump2_idle_done", mem_process_done, 0);
        check("dump2_rearmed", dump_busy, 1);
        sb.push_back('{port: 1, err: 0, rdata: 32'h0});
        drive_port(1, 1, 30'd9, 32'h00000055);
        @(negedge clk);
        check("dump2_pulse", mem_process_done, 1);
        check("dump_beats_req", m1_ack, 0);
        @(negedge clk);
        check("dump2_clear_done", mem_process_done, 0);
        check("dump2_clear_busy", dump_busy, 0);
        @(negedge clk);
        check("after_dump_m1_ack", m1_ack, 1);
        m1_req = 1'b0;

        // Reset during RESP aborts the read and clears pending dump and rr history.
        @(negedge clk);
        drive_port(0, 0, 30'd5, '0);
        @(negedge clk);
        dump_req = 1'b1;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
        check("pre_rst_resp_ack", m0_ack, 1);
        check("pre_rst_busy", dump_busy, 1);
        #1;
        rstN = 1'b0;
        #1;
        check("rst_abort_ack", {m0_ack, m1_ack}, 0);
        check("rst_abort_rdata", m0_rdata, 0);
        check("rst_abort_busy", dump_busy, 0);
        check("rst_abort_strobe", {mem_read_En, mem_write_En, mem_process_done}, 0);
        m0_req = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("post_rst_quiet", {m0_ack, m1_ack, mem_read_En, mem_write_En}, 0);
        sb.push_back('{port: 0, err: 0, rdata: 32'hDEADBEEF});
        sb.push_back('{port: 1, err: 0, rdata: 32'h0});
        drive_port(0, 0, 30'd5, '0);
        drive_port(1, 1, 30'd11, 32'h0000BEEF);
        run_both(1, 1, "post_rst");

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
